// File: rtl/subword_seq_pkg.sv
// Shared types, ids and S-box arithmetic for the time-multiplexed SubWord engine.
package subword_seq_pkg;

    typedef logic [7:0] byte_t;
    typedef byte_t [3:0] word_t;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic ID_KX = 1'b0;
    localparam logic ID_CS = 1'b1;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    function automatic byte_t gf_mul(input byte_t a, input byte_t b);
        byte_t p;
        byte_t aa;
        byte_t bb;
        p  = '0;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Inverse as x^254 (x^2 * x^4 * ... * x^128), which also maps 0 to 0.
    function automatic byte_t sbox_calc(input byte_t x);
        byte_t inv;
        byte_t sq;
        inv = 8'h01;
        sq  = x;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/subword_arb2.sv
// Two-way grant between key expansion and cipher state, round-robin or kx-first.
module subword_arb2
    import subword_seq_pkg::*;
#(
    parameter int ARB_MODE = ARB_RR
) (
    input  logic clk,
    input  logic rst,
    input  logic grant_en,
    input  logic req_kx,
    input  logic req_cs,
    output logic gnt_kx,
    output logic gnt_cs
);

    logic last_grant_q, last_grant_d;
    logic pick_cs;

    always_comb begin
        pick_cs = req_cs;
        if (req_kx && req_cs) begin
            pick_cs = (ARB_MODE == ARB_FIXED) ? 1'b0 : (last_grant_q == ID_KX);
        end
        gnt_kx = grant_en && req_kx && !pick_cs;
        gnt_cs = grant_en && req_cs && pick_cs;

        last_grant_d = last_grant_q;
        if (gnt_kx) last_grant_d = ID_KX;
        if (gnt_cs) last_grant_d = ID_CS;
    end

    // Reset to cs so that kx wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) last_grant_q <= ID_CS;
        else     last_grant_q <= last_grant_d;
    end

endmodule

// File: rtl/subword_seq_sbox.sv
// Combinational AES forward S-box.
module subword_seq_sbox
    import subword_seq_pkg::*;
(
    input  byte_t in_byte,
    output byte_t out_byte
);

    assign out_byte = sbox_calc(in_byte);

endmodule

// File: rtl/subword_seq.sv
// SubWord engine: BYTES_PER_CYCLE shared S-boxes serialise a 32-bit word.
// Define SUBWORD_SEQ_PIPE_EN to register the S-box outputs (BUSY grows by one cycle).
//
//   state | meaning
//   IDLE  | waiting for a request, grant ready to the arbitration winner
//   BUSY  | pushing bytes through the S-boxes into the result register
//   DONE  | result presented on o_valid until the consumer takes it
module subword_seq
    import subword_seq_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 1,
    parameter int ARB_MODE        = ARB_RR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        kx_valid,
    output logic        kx_ready,
    input  logic [31:0] kx_word,
    input  logic        cs_valid,
    output logic        cs_ready,
    input  logic [31:0] cs_word,
    output logic        o_valid,
    input  logic        o_ready,
    output logic [31:0] o_word,
    output logic        o_id,
    output logic        busy
);

    localparam logic [1:0] STEP     = 2'(BYTES_PER_CYCLE);
    localparam logic [1:0] LAST_IDX = 2'(4 - BYTES_PER_CYCLE);

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    word_t      data_q, data_d;
    word_t      res_q, res_d;
    logic       id_q, id_d;
    logic       o_valid_q, o_valid_d;

    logic       gnt_kx, gnt_cs;
    logic       issue, wr_en, wr_last;
    logic [1:0] wr_idx;
    byte_t      sb_out  [BYTES_PER_CYCLE];
    byte_t      wr_byte [BYTES_PER_CYCLE];

    subword_arb2 #(.ARB_MODE(ARB_MODE)) u_arb (
        .clk      (clk),
        .rst      (rst),
        .grant_en (state_q == IDLE),
        .req_kx   (kx_valid),
        .req_cs   (cs_valid),
        .gnt_kx   (gnt_kx),
        .gnt_cs   (gnt_cs)
    );

    for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_sbox
        subword_seq_sbox u_sbox (
            .in_byte  (data_q[idx_q + 2'(g)]),
            .out_byte (sb_out[g])
        );
    end

`ifdef SUBWORD_SEQ_PIPE_EN
    byte_t      pipe_q [BYTES_PER_CYCLE];
    byte_t      pipe_d [BYTES_PER_CYCLE];
    logic [1:0] pipe_idx_q, pipe_idx_d;
    logic       pipe_vld_q, pipe_vld_d;

    // Stop issuing once the last group sits in the stage; the extra cycle only drains it.
    assign wr_en   = pipe_vld_q;
    assign wr_idx  = pipe_idx_q;
    assign wr_byte = pipe_q;
    assign wr_last = pipe_vld_q && (pipe_idx_q == LAST_IDX);
    assign issue   = (state_q == BUSY) && !wr_last;

    always_comb begin
        pipe_vld_d = issue;
        pipe_idx_d = idx_q;
        for (int i = 0; i < BYTES_PER_CYCLE; i++) pipe_d[i] = sb_out[i];
    end
`else
    assign wr_en   = (state_q == BUSY);
    assign wr_idx  = idx_q;
    assign wr_byte = sb_out;
    assign wr_last = wr_en && (idx_q == LAST_IDX);
    assign issue   = wr_en;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        data_d    = data_q;
        res_d     = res_q;
        id_d      = id_q;
        o_valid_d = o_valid_q;

        if (wr_en) begin
            for (int i = 0; i < BYTES_PER_CYCLE; i++) res_d[wr_idx + 2'(i)] = wr_byte[i];
        end

        case (state_q)
            IDLE: begin
                if (gnt_kx || gnt_cs) begin
                    data_d  = gnt_cs ? cs_word : kx_word;
                    id_d    = gnt_cs ? ID_CS : ID_KX;
                    idx_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (issue) idx_d = idx_q + STEP;
                if (wr_last) begin
                    idx_d     = '0;
                    state_d   = DONE;
                    o_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (o_ready) begin
                    state_d   = IDLE;
                    o_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            data_q    <= '0;
            res_q     <= '0;
            id_q      <= 1'b0;
            o_valid_q <= 1'b0;
`ifdef SUBWORD_SEQ_PIPE_EN
            pipe_idx_q <= '0;
            pipe_vld_q <= 1'b0;
            for (int i = 0; i < BYTES_PER_CYCLE; i++) pipe_q[i] <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            res_q     <= res_d;
            id_q      <= id_d;
            o_valid_q <= o_valid_d;
`ifdef SUBWORD_SEQ_PIPE_EN
            pipe_idx_q <= pipe_idx_d;
            pipe_vld_q <= pipe_vld_d;
            for (int i = 0; i < BYTES_PER_CYCLE; i++) pipe_q[i] <= pipe_d[i];
`endif
        end
    end

    assign kx_ready = gnt_kx;
    assign cs_ready = gnt_cs;
    assign o_valid  = o_valid_q;
    assign o_word   = res_q;
    assign o_id     = id_q;
    assign busy     = (state_q != IDLE);

    a_idx_in_range: assert property (@(posedge clk) disable iff (rst)
        (state_q == BUSY) |-> (({1'b0, idx_q} + 3'(BYTES_PER_CYCLE)) <= 3'd4));

endmodule

// File: tb/tb_subword_seq.sv
// Bench for subword_seq: four instances (B=1 rr, B=1 fixed, B=2, B=4) against a transaction-level model.
module tb_subword_seq;

`ifdef SUBWORD_SEQ_PIPE_EN
    localparam int PIPE = 1;
`else
    localparam int PIPE = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        kx_valid [4];
    logic        cs_valid [4];
    logic        o_ready  [4];
    logic [31:0] kx_word  [4];
    logic [31:0] cs_word  [4];
    logic        kx_ready [4];
    logic        cs_ready [4];
    logic        o_valid  [4];
    logic        o_id     [4];
    logic        busy     [4];
    logic [31:0] o_word   [4];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        localparam int BP = (gi == 2) ? 2 : ((gi == 3) ? 4 : 1);
        localparam int AP = (gi == 1) ? 1 : 0;
        subword_seq #(.BYTES_PER_CYCLE(BP), .ARB_MODE(AP)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .kx_valid (kx_valid[gi]),
            .kx_ready (kx_ready[gi]),
            .kx_word  (kx_word[gi]),
            .cs_valid (cs_valid[gi]),
            .cs_ready (cs_ready[gi]),
            .cs_word  (cs_word[gi]),
            .o_valid  (o_valid[gi]),
            .o_ready  (o_ready[gi]),
            .o_word   (o_word[gi]),
            .o_id     (o_id[gi]),
            .busy     (busy[gi])
        );
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] m_sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] c;
        logic [7:0] s;
        inv = 8'h00;
        c   = 8'h63;
        for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
        return s;
    endfunction

    function automatic logic [31:0] m_subword(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = m_sbox(w[8*i +: 8]);
        return r;
    endfunction

    function automatic int lat_of(input int d);
        int b;
        b = (d == 2) ? 2 : ((d == 3) ? 4 : 1);
        return 4 / b + PIPE;
    endfunction

    bit          started = 0;
    bit          mb  [4];
    int          mc  [4];
    bit          mo  [4];
    bit          ml  [4];
    bit          mid [4];
    logic [31:0] mw  [4];

    function automatic void m_grant(input int d, output bit any, output bit g);
        any = kx_valid[d] || cs_valid[d];
        if (kx_valid[d] && cs_valid[d]) g = (d == 1) ? 1'b0 : !ml[d];
        else                            g = cs_valid[d];
    endfunction

    always @(posedge clk) begin : model
        bit any, g;
        if (rst) begin
            started = 1;
            for (int d = 0; d < 4; d++) begin
                mb[d] = 0; mc[d] = 0; mo[d] = 0; ml[d] = 1; mid[d] = 0; mw[d] = '0;
            end
        end else begin
            for (int d = 0; d < 4; d++) begin
                if (mo[d]) begin
                    if (o_ready[d]) begin mo[d] = 0; mb[d] = 0; end
                end else if (mb[d]) begin
                    mc[d]--;
                    if (mc[d] == 0) mo[d] = 1;
                end else begin
                    m_grant(d, any, g);
                    if (any) begin
                        mb[d] = 1; mc[d] = lat_of(d); mid[d] = g; ml[d] = g;
                        mw[d] = m_subword(g ? cs_word[d] : kx_word[d]);
                    end
                end
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : compare
        bit any, g;
        if (started) begin
            for (int d = 0; d < 4; d++) begin
                m_grant(d, any, g);
                chk($sformatf("d%0d_kx_ready", d), 32'(kx_ready[d]), 32'(!mb[d] && any && !g));
                chk($sformatf("d%0d_cs_ready", d), 32'(cs_ready[d]), 32'(!mb[d] && any && g));
                chk($sformatf("d%0d_o_valid", d), 32'(o_valid[d]), 32'(mo[d]));
                chk($sformatf("d%0d_busy", d), 32'(busy[d]), 32'(mb[d]));
                if (mo[d]) begin
                    chk($sformatf("d%0d_o_word", d), o_word[d], mw[d]);
                    chk($sformatf("d%0d_o_id", d), 32'(o_id[d]), 32'(mid[d]));
                end
            end
        end
    end

    // ---------------- event recorder for the DUT under test ----------------
    int          cur_dut = 0;
    int          gq[$];
    logic [31:0] oq_w[$];
    int          oq_id[$];
    int          hs_n, kr_n, cr_n, ov_n, acc_cyc, ov_cyc;
    bit          ov_prev = 0;

    always @(negedge clk) begin : recorder
        int d;
        d = cur_dut;
        if (kx_valid[d] && kx_ready[d]) begin gq.push_back(0); acc_cyc = cyc; hs_n++; end
        if (cs_valid[d] && cs_ready[d]) begin gq.push_back(1); acc_cyc = cyc; hs_n++; end
        if (kx_ready[d]) kr_n++;
        if (cs_ready[d]) cr_n++;
        if (o_valid[d]) begin
            ov_n++;
            if (!ov_prev && ov_cyc < 0) ov_cyc = cyc;
            if (o_ready[d]) begin oq_w.push_back(o_word[d]); oq_id.push_back(int'(o_id[d])); end
        end
        ov_prev = o_valid[d];
    end

    task automatic clear_rec();
        gq.delete(); oq_w.delete(); oq_id.delete();
        hs_n = 0; kr_n = 0; cr_n = 0; ov_n = 0; acc_cyc = -1; ov_cyc = -1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic single_req(input int d, input bit is_cs, input logic [31:0] w);
        tick();
        cur_dut = d;
        clear_rec();
        if (is_cs) begin cs_word[d] = w; cs_valid[d] = 1'b1; end
        else       begin kx_word[d] = w; kx_valid[d] = 1'b1; end
        for (int i = 0; i < 40; i++) begin
            tick();
            if (hs_n > 0) break;
        end
        chk("accept_count", 32'(hs_n), 32'd1);
        kx_valid[d] = 1'b0;
        cs_valid[d] = 1'b0;
    endtask

    task automatic wait_ov(input int lim);
        for (int i = 0; i < lim; i++) begin
            if (ov_cyc >= 0) break;
            tick();
        end
        chk("o_valid_seen", 32'(ov_cyc >= 0), 32'd1);
    endtask

    task automatic wait_outs(input int n, input int lim);
        for (int i = 0; i < lim; i++) begin
            if (oq_w.size() >= n) break;
            tick();
        end
        chk("out_count", 32'(oq_w.size()), 32'(n));
    endtask

    task automatic hold_both(input int d, input logic [31:0] kw, input logic [31:0] cw, input int n);
        tick();
        cur_dut = d;
        clear_rec();
        kx_word[d] = kw; cs_word[d] = cw;
        kx_valid[d] = 1'b1; cs_valid[d] = 1'b1;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (gq.size() >= n) break;
        end
        kx_valid[d] = 1'b0; cs_valid[d] = 1'b0;
        chk("grant_count", 32'(gq.size()), 32'(n));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        for (int d = 0; d < 4; d++) begin
            kx_valid[d] = 1'b0; cs_valid[d] = 1'b0; o_ready[d] = 1'b1;
            kx_word[d] = '0; cs_word[d] = '0;
        end
        clear_rec();
        tick();
        tick();
        rst = 1'b0;

        // reset state
        chk("rst_o_valid", 32'(o_valid[0]), 32'd0);
        chk("rst_busy", 32'(busy[0]), 32'd0);
        chk("rst_o_word", o_word[0], 32'h0);
        chk("rst_o_id", 32'(o_id[0]), 32'd0);
        chk("rst_kx_ready", 32'(kx_ready[0]), 32'd0);
        chk("rst_cs_ready", 32'(cs_ready[0]), 32'd0);

        // pin the model's S-box
        chk("model_sbox_00", 32'(m_sbox(8'h00)), 32'h63);
        chk("model_sbox_01", 32'(m_sbox(8'h01)), 32'h7c);
        chk("model_sbox_53", 32'(m_sbox(8'h53)), 32'hed);
        chk("model_sbox_ff", 32'(m_sbox(8'hff)), 32'h16);

        // single kx request, B=1
        single_req(0, 1'b0, 32'hff530100);
        wait_ov(20);
        chk("b1_latency", 32'(ov_cyc - acc_cyc), 32'(5 + PIPE));
        chk("b1_kx_ready_cycles", 32'(kr_n), 32'd1);
        wait_outs(1, 10);
        if (oq_w.size() > 0) begin
            chk("b1_o_word", oq_w[0], 32'h16ed7c63);
            chk("b1_o_id", 32'(oq_id[0]), 32'd0);
        end

        // round-robin tie
        do_reset();
        hold_both(0, 32'h01000053, 32'h00000000, 3);
        wait_outs(3, 40);
        if (gq.size() >= 3) begin
            chk("rr_grant0", 32'(gq[0]), 32'd0);
            chk("rr_grant1", 32'(gq[1]), 32'd1);
            chk("rr_grant2", 32'(gq[2]), 32'd0);
        end
        if (oq_w.size() >= 3) begin
            chk("rr_kx_word", oq_w[0], 32'h7c6363ed);
            chk("rr_cs_word", oq_w[1], 32'h63636363);
            chk("rr_cs_id", 32'(oq_id[1]), 32'd1);
        end

        // fixed priority
        do_reset();
        hold_both(1, 32'hff530100, 32'h00000000, 3);
        wait_outs(3, 40);
        if (gq.size() >= 3) begin
            chk("fx_grant0", 32'(gq[0]), 32'd0);
            chk("fx_grant1", 32'(gq[1]), 32'd0);
            chk("fx_grant2", 32'(gq[2]), 32'd0);
        end
        chk("fx_cs_ready_cycles", 32'(cr_n), 32'd0);

        // backpressure
        tick();
        o_ready[0] = 1'b0;
        single_req(0, 1'b0, 32'hff530100);
        wait_ov(20);
        cs_word[0]  = 32'h12345678;
        cs_valid[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_o_valid", 32'(o_valid[0]), 32'd1);
            chk("bp_o_word", o_word[0], 32'h16ed7c63);
            chk("bp_o_id", 32'(o_id[0]), 32'd0);
            chk("bp_kx_ready", 32'(kx_ready[0]), 32'd0);
            chk("bp_cs_ready", 32'(cs_ready[0]), 32'd0);
        end
        o_ready[0] = 1'b1;
        tick();
        chk("bp_idle_after_release", 32'(busy[0]), 32'd0);
        chk("bp_cs_ready_in_idle", 32'(cs_ready[0]), 32'd1);
        cs_valid[0] = 1'b0;

        // reset in the middle of BUSY
        tick();
        cur_dut = 0;
        clear_rec();
        kx_word[0]  = 32'hff530100;
        kx_valid[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (hs_n > 0) break;
        end
        chk("mid_accept", 32'(hs_n), 32'd1);
        kx_valid[0] = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_o_valid", 32'(o_valid[0]), 32'd0);
        chk("mid_busy", 32'(busy[0]), 32'd0);
        chk("mid_o_word", o_word[0], 32'h0);
        chk("mid_o_id", 32'(o_id[0]), 32'd0);
        clear_rec();
        repeat (8) tick();
        chk("mid_no_response", 32'(ov_n), 32'd0);
        hold_both(0, 32'h01000053, 32'h00000000, 1);
        wait_outs(1, 20);
        if (gq.size() >= 1) chk("mid_first_tie_kx", 32'(gq[0]), 32'd0);
        if (oq_w.size() >= 1) chk("mid_fresh_word", oq_w[0], 32'h7c6363ed);

        // B=2 and B=4
        single_req(2, 1'b0, 32'h01000053);
        wait_ov(20);
        chk("b2_latency", 32'(ov_cyc - acc_cyc), 32'(3 + PIPE));
        wait_outs(1, 10);
        if (oq_w.size() >= 1) chk("b2_o_word", oq_w[0], 32'h7c6363ed);

        single_req(3, 1'b1, 32'h01000053);
        wait_ov(20);
        chk("b4_latency", 32'(ov_cyc - acc_cyc), 32'(2 + PIPE));
        wait_outs(1, 10);
        if (oq_w.size() >= 1) begin
            chk("b4_o_word", oq_w[0], 32'h7c6363ed);
            chk("b4_o_id", 32'(oq_id[0]), 32'd1);
        end

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
